// File: rtl/security_pkg.sv
// Shared types and constants for the zoned intrusion controller.
// The optional exit delay is enabled by defining SECURITY_EXIT_DELAY_EN.
package security_pkg;

    // One-hot-0 state encoding; DISARMED is the all-zero state.
    typedef enum logic [3:0] {
        DISARMED    = 4'b0000,
        EXIT_DELAY  = 4'b0001,
        ARMED       = 4'b0010,
        ENTRY_DELAY = 4'b0100,
        ALARM       = 4'b1000
    } state_t;

    localparam logic [3:0] DEF_ARM_CODE    = 4'b0011;
    localparam logic [3:0] DEF_DISARM_CODE = 4'b1100;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/security_delay_timer.sv
// Up-counting delay timer shared by the exit, entry and siren phases.
// done is high while the count sits at limit (limit = delay length - 1).
module security_delay_timer #(
    parameter int W = 4
) (
    input  logic         sys_clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] count;

    // Count from zero after clear, holding at the limit so it can never wrap.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != limit)) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == limit);

endmodule

// File: rtl/security_zoned.sv
// Multi-zone intrusion controller: arming/disarming by keypad code, per-zone
// bypass latched at arming, entry and siren delays, wrong-code escalation and
// a sticky record of tripped zones. All outputs are registered.
// Define SECURITY_EXIT_DELAY_EN to insert an exit delay between arming and ARMED;
// without it the ARM code goes straight to ARMED and is_exit_delay stays 0.
module security_zoned
    import security_pkg::*;
#(
    parameter int               N_ZONES      = 3,
    parameter int               KEY_W        = 4,
    parameter logic [KEY_W-1:0] ARM_CODE     = KEY_W'(DEF_ARM_CODE),
    parameter logic [KEY_W-1:0] DISARM_CODE  = KEY_W'(DEF_DISARM_CODE),
    parameter int               ENTRY_CYCLES = 100,
    parameter int               EXIT_CYCLES  = 200,
    parameter int               SIREN_CYCLES = 1000,
    parameter int               MAX_BAD      = 3
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic [KEY_W-1:0]   keypad,
    input  logic               keypad_valid,
    input  logic [N_ZONES-1:0] zone_in,
    input  logic [N_ZONES-1:0] zone_bypass,
    output logic               alarm_siren,
    output logic               is_armed,
    output logic               is_wait_delay,
    output logic               is_exit_delay,
    output logic [N_ZONES-1:0] tripped_zones
);

    localparam int TW = $clog2(max3(ENTRY_CYCLES, EXIT_CYCLES, SIREN_CYCLES) + 1);
    localparam int BW = $clog2(MAX_BAD + 1);

    localparam logic [TW-1:0] ENTRY_LIM = TW'(ENTRY_CYCLES - 1);
    localparam logic [TW-1:0] SIREN_LIM = TW'(SIREN_CYCLES - 1);
`ifdef SECURITY_EXIT_DELAY_EN
    localparam logic [TW-1:0] EXIT_LIM  = TW'(EXIT_CYCLES - 1);
`endif
    localparam logic [BW-1:0] BAD_MAX   = BW'(MAX_BAD);

    state_t             state, state_next;
    logic [N_ZONES-1:0] bypass_q;
    logic [BW-1:0]      bad_cnt, bad_next;
    logic [TW-1:0]      limit;
    logic               timer_clear, timer_enable, timer_done;
    logic               code_arm, code_disarm, code_other, trip, arming, watching;

    assign code_arm    = keypad_valid && (keypad == ARM_CODE);
    assign code_disarm = keypad_valid && (keypad == DISARM_CODE);
    assign code_other  = keypad_valid && (keypad != DISARM_CODE);
    assign trip        = |(zone_in & ~bypass_q);
    assign arming      = (state == DISARMED) && (state_next != DISARMED);
    assign watching    = (state == ARMED) || (state == ENTRY_DELAY) || (state == ALARM);

    // The timer restarts on every state change, so each timed state begins at zero.
    assign timer_clear = (state_next != state);

    // Select the terminal count for whichever timed state is active.
    always_comb begin
        limit        = '0;
        timer_enable = 1'b0;
        case (state)
`ifdef SECURITY_EXIT_DELAY_EN
            EXIT_DELAY: begin
                limit        = EXIT_LIM;
                timer_enable = 1'b1;
            end
`endif
            ENTRY_DELAY: begin
                limit        = ENTRY_LIM;
                timer_enable = 1'b1;
            end
            ALARM: begin
                limit        = SIREN_LIM;
                timer_enable = 1'b1;
            end
            default: ;
        endcase
    end

    security_delay_timer #(.W(TW)) u_timer (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .limit   (limit),
        .done    (timer_done)
    );

    // Next-state and wrong-code counter; codes take priority over timer expiry.
    always_comb begin
        state_next = state;
        bad_next   = bad_cnt;
        case (state)
            DISARMED: begin
                if (code_arm) begin
`ifdef SECURITY_EXIT_DELAY_EN
                    state_next = EXIT_DELAY;
`else
                    state_next = ARMED;
`endif
                end
            end
`ifdef SECURITY_EXIT_DELAY_EN
            EXIT_DELAY: begin
                if (code_disarm)     state_next = DISARMED;
                else if (timer_done) state_next = ARMED;
            end
`endif
            ARMED: begin
                if (code_disarm) state_next = DISARMED;
                else if (trip)   state_next = ENTRY_DELAY;
            end
            ENTRY_DELAY: begin
                if (code_disarm) begin
                    state_next = DISARMED;
                end else begin
                    if (code_other && (bad_cnt != BAD_MAX)) bad_next = bad_cnt + 1'b1;
                    if ((code_other && (bad_next == BAD_MAX)) || timer_done)
                        state_next = ALARM;
                end
            end
            ALARM: begin
                if (code_disarm)     state_next = DISARMED;
                else if (timer_done) state_next = ARMED;
            end
            default: state_next = DISARMED;
        endcase
        if ((state_next == DISARMED) || (state_next == ARMED)) bad_next = '0;
    end

    // State, bypass mask, wrong-code count and the sticky trip record.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state         <= DISARMED;
            bad_cnt       <= '0;
            bypass_q      <= '0;
            tripped_zones <= '0;
        end else begin
            state   <= state_next;
            bad_cnt <= bad_next;
            if (arming) begin
                bypass_q      <= zone_bypass;
                tripped_zones <= '0;
            end else if (watching) begin
                tripped_zones <= tripped_zones | (zone_in & ~bypass_q);
            end
        end
    end

    // Status outputs are flopped from the next state so they change with the state.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            alarm_siren   <= 1'b0;
            is_armed      <= 1'b0;
            is_wait_delay <= 1'b0;
        end else begin
            alarm_siren   <= (state_next == ALARM);
            is_armed      <= (state_next == ARMED);
            is_wait_delay <= (state_next == ENTRY_DELAY);
        end
    end

`ifdef SECURITY_EXIT_DELAY_EN
    // Exit-delay indicator, present only when the exit delay is built in.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) is_exit_delay <= 1'b0;
        else       is_exit_delay <= (state_next == EXIT_DELAY);
    end
`else
    assign is_exit_delay = 1'b0;
`endif

endmodule

// File: tb/tb_security_zoned.sv
// Scoreboard bench for security_zoned: each driven cycle pushes the reference
// model's predicted outputs; a monitor pops and compares after every clock edge.
module tb_security_zoned;

    localparam int ENTRY_C = 6;
    localparam int EXIT_C  = 4;
    localparam int SIREN_C = 9;
    localparam int MAXB    = 3;
    localparam logic [3:0] ARM_K = 4'b0011;
    localparam logic [3:0] DIS_K = 4'b1100;
`ifdef SECURITY_EXIT_DELAY_EN
    localparam bit EXIT_EN = 1'b1;
`else
    localparam bit EXIT_EN = 1'b0;
`endif

    localparam int M_OFF = 0, M_EXIT = 1, M_ARMED = 2, M_ENTRY = 3, M_ALARM = 4;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic [3:0] keypad;
    logic       keypad_valid;
    logic [2:0] zone_in, zone_bypass;
    logic       alarm_siren, is_armed, is_wait_delay, is_exit_delay;
    logic [2:0] tripped_zones;

    security_zoned #(
        .N_ZONES(3), .KEY_W(4), .ARM_CODE(ARM_K), .DISARM_CODE(DIS_K),
        .ENTRY_CYCLES(ENTRY_C), .EXIT_CYCLES(EXIT_C), .SIREN_CYCLES(SIREN_C), .MAX_BAD(MAXB)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .keypad(keypad), .keypad_valid(keypad_valid),
        .zone_in(zone_in), .zone_bypass(zone_bypass), .alarm_siren(alarm_siren),
        .is_armed(is_armed), .is_wait_delay(is_wait_delay), .is_exit_delay(is_exit_delay),
        .tripped_zones(tripped_zones)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors = 0;
    int miscompares = 0;
    logic [6:0] exp_q[$];

    // Reference model: mode, cycles left in the timed mode, wrong codes, bypass, record.
    int m_mode, m_left, m_bad;
    logic [2:0] m_byp, m_rec;

    task automatic model_reset();
        m_mode = M_OFF; m_left = 0; m_bad = 0; m_byp = '0; m_rec = '0;
    endtask

    task automatic model_step(input logic [3:0] k, input logic v, input logic [2:0] z,
                              input logic [2:0] b);
        logic [2:0] hit;
        logic dis;
        hit = z & ~m_byp;
        dis = v && (k == DIS_K);
        if (m_mode == M_ARMED || m_mode == M_ENTRY || m_mode == M_ALARM) m_rec = m_rec | hit;
        case (m_mode)
            M_OFF: if (v && k == ARM_K) begin
                m_rec = '0; m_byp = b; m_bad = 0;
                if (EXIT_EN) begin m_mode = M_EXIT; m_left = EXIT_C; end
                else m_mode = M_ARMED;
            end
            M_EXIT: if (dis) m_mode = M_OFF;
                    else begin m_left--; if (m_left == 0) m_mode = M_ARMED; end
            M_ARMED: if (dis) m_mode = M_OFF;
                     else if (hit != 0) begin m_mode = M_ENTRY; m_left = ENTRY_C; m_bad = 0; end
            M_ENTRY: if (dis) m_mode = M_OFF;
                     else begin
                         if (v) m_bad++;
                         m_left--;
                         if (m_bad >= MAXB || m_left == 0) begin m_mode = M_ALARM; m_left = SIREN_C; end
                     end
            M_ALARM: if (dis) m_mode = M_OFF;
                     else begin m_left--; if (m_left == 0) m_mode = M_ARMED; end
            default: m_mode = M_OFF;
        endcase
    endtask

    function automatic logic [6:0] model_out();
        return {m_mode == M_ALARM, m_mode == M_ARMED, m_mode == M_ENTRY, m_mode == M_EXIT, m_rec};
    endfunction

    task automatic apply(input logic [3:0] k, input logic v, input logic [2:0] z, input logic [2:0] b);
        keypad = k; keypad_valid = v; zone_in = z; zone_bypass = b;
        model_step(k, v, z, b);
        exp_q.push_back(model_out());
    endtask

    task automatic cycle(input logic [3:0] k, input logic v, input logic [2:0] z, input logic [2:0] b);
        @(negedge sys_clk);
        apply(k, v, z, b);
    endtask

    task automatic idle(input int n, input logic [2:0] z);
        repeat (n) cycle(4'h0, 1'b0, z, 3'b000);
    endtask

    task automatic check_zero(input string name);
        logic [6:0] a;
        a = {alarm_siren, is_armed, is_wait_delay, is_exit_delay, tripped_zones};
        vectors++;
        if (a !== 7'b0) begin
            miscompares++;
            $display("FAIL %s: got %b want 0000000", name, a);
        end
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(posedge sys_clk);
        #2 reset = 1'b1;
        #1 check_zero("async_reset");
        model_reset();
        @(negedge sys_clk);
        reset = 1'b0;
        apply(4'h0, 1'b0, 3'b000, 3'b000);
    endtask

    // Monitor: one prediction per functional edge.
    initial begin
        logic [6:0] e, a;
        forever begin
            @(posedge sys_clk);
            #1;
            if (!reset) begin
                vectors++;
                a = {alarm_siren, is_armed, is_wait_delay, is_exit_delay, tripped_zones};
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard_empty at %0t: got %b", $time, a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        miscompares++;
                        $display("FAIL outputs at %0t: got siren/armed/wait/exit/trip=%b want %b",
                                 $time, a, e);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; keypad = '0; keypad_valid = 1'b0; zone_in = '0; zone_bypass = '0;
        model_reset();
        #3 check_zero("power_on_reset");
        @(negedge sys_clk);
        reset = 1'b0;
        apply(4'h0, 1'b0, 3'b000, 3'b000);

        // Full cycle: arm, exit delay, trip, entry delay, siren, auto re-arm.
        cycle(ARM_K, 1'b1, 3'b000, 3'b000);
        idle(EXIT_C + 2, 3'b000);
        cycle(4'h0, 1'b0, 3'b001, 3'b000);
        idle(ENTRY_C + SIREN_C + 3, 3'b000);
        cycle(DIS_K, 1'b1, 3'b000, 3'b000);

        // Disarm partway through the entry delay keeps the record.
        cycle(ARM_K, 1'b1, 3'b000, 3'b000);
        idle(EXIT_C + 1, 3'b000);
        cycle(4'h0, 1'b0, 3'b001, 3'b000);
        idle(2, 3'b000);
        cycle(DIS_K, 1'b1, 3'b000, 3'b000);
        idle(3, 3'b000);

        // Bypassed zone is ignored, unbypassed zone trips.
        cycle(ARM_K, 1'b1, 3'b000, 3'b010);
        idle(EXIT_C + 1, 3'b010);
        idle(4, 3'b010);
        cycle(4'h0, 1'b0, 3'b100, 3'b000);
        idle(2, 3'b000);
        cycle(DIS_K, 1'b1, 3'b000, 3'b000);

        // Wrong codes escalate before the entry timer expires.
        cycle(ARM_K, 1'b1, 3'b000, 3'b000);
        idle(EXIT_C + 1, 3'b000);
        cycle(4'h0, 1'b0, 3'b001, 3'b000);
        repeat (MAXB) cycle(4'b0000, 1'b1, 3'b000, 3'b000);
        idle(3, 3'b000);
        cycle(DIS_K, 1'b1, 3'b000, 3'b000);

        // Disarm on the final entry-delay cycle.
        cycle(ARM_K, 1'b1, 3'b000, 3'b000);
        idle(EXIT_C + 1, 3'b000);
        cycle(4'h0, 1'b0, 3'b001, 3'b000);
        idle(ENTRY_C - 1, 3'b000);
        cycle(DIS_K, 1'b1, 3'b000, 3'b000);
        idle(2, 3'b000);

        // Wrong code on the final entry-delay cycle still alarms.
        cycle(ARM_K, 1'b1, 3'b000, 3'b000);
        idle(EXIT_C + 1, 3'b000);
        cycle(4'h0, 1'b0, 3'b010, 3'b000);
        idle(ENTRY_C - 1, 3'b000);
        cycle(4'b0101, 1'b1, 3'b000, 3'b000);
        idle(2, 3'b000);

        // Re-arm from the siren with a zone still open, then reset mid-alarm.
        idle(SIREN_C + 2, 3'b001);
        idle(ENTRY_C + 2, 3'b000);
        do_reset();

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] k;
            logic       v;
            logic [2:0] z;
            int         r;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                continue;
            end
            v = ($urandom_range(0, 99) < 15);
            r = $urandom_range(0, 9);
            k = (r < 4) ? ARM_K : (r < 7) ? DIS_K : 4'($urandom_range(0, 15));
            z = ($urandom_range(0, 9) < 7) ? 3'b000 : 3'($urandom_range(0, 7));
            cycle(k, v, z, 3'($urandom_range(0, 7)));
        end

        @(posedge sys_clk);
        #2;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
